// File: rtl/decimal_counter_pkg.sv
// Shared BCD definitions for the decimal event counter.
package decimal_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Next value of a single BCD digit on an increment, wrapping 9 -> 0.
    function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
        if (d == BCD_MAX) begin
            return BCD_ZERO;
        end
        return d + 4'd1;
    endfunction

endpackage

// File: rtl/decimal_counter_digit.sv
// One BCD digit of the decimal counter: holds 0-9 and produces a carry
// when it is incremented from 9. Clocked by the counted signal itself.
module bcd_digit
    import decimal_counter_pkg::*;
(
    input  logic       sigIn,
    input  logic       reset,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Next-state: reset clears, an increment advances with 9 -> 0 wrap, else hold.
    always_comb begin
        digit_d = digit_q;
        if (reset) begin
            digit_d = BCD_ZERO;
        end else if (inc) begin
            digit_d = bcd_next(digit_q);
        end
    end

    // Digit register; the only state in this block.
    always_ff @(posedge sigIn) begin
        digit_q <= digit_d;
    end

    // Carry is combinational on the registered digit so the whole chain
    // settles within one sigIn period with no ripple registers.
    assign carry = inc & (digit_q == BCD_MAX);
    assign digit = digit_q;

endmodule

// File: rtl/decimal_counter.sv
// Multi-digit packed-BCD event counter. Counts rising edges of sigIn while
// enable is high; count[3:0] is the units digit.
module decimal_counter
    import decimal_counter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  sigIn,
    input  logic                  reset,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   count
);

    // inc_chain[k] is the increment request into digit k; the entry past the
    // top digit is the wrap carry, which is deliberately discarded.
    logic [DIGITS:0] inc_chain;
    logic            unused_wrap_carry;

    assign inc_chain[0]      = enable;
    assign unused_wrap_carry = inc_chain[DIGITS];

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] digit_w;

            bcd_digit u_digit (
                .sigIn (sigIn),
                .reset (reset),
                .inc   (inc_chain[k]),
                .digit (digit_w),
                .carry (inc_chain[k+1])
            );

            assign count[4*k +: 4] = digit_w;
        end
    endgenerate

endmodule

// File: tb/tb_decimal_counter.sv
// Directed bench for the four-digit BCD event counter.
module tb_decimal_counter;

    logic        sigIn;
    logic        reset;
    logic        enable;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    decimal_counter #(.DIGITS(4)) dut (
        .sigIn  (sigIn),
        .reset  (reset),
        .enable (enable),
        .count  (count)
    );

    initial begin
        sigIn = 1'b0;
        forever #5 sigIn = ~sigIn;
    end

    // Every nibble must be a legal BCD code after every edge once reset is done.
    always @(posedge sigIn) begin
        #1;
        if (chk_on) begin
            for (int n = 0; n < 4; n++) begin
                total++;
                if (count[4*n +: 4] > 4'd9) begin
                    bad++;
                    $display("FAIL nibble_legal[%0d]: got count=%h, required every nibble <= 9", n, count);
                end
            end
        end
    end

    // Apply n edges with the given inputs; returns 1 ns after the last edge.
    task automatic edges(input int n, input logic en, input logic rst);
        for (int i = 0; i < n; i++) begin
            enable = en;
            reset  = rst;
            @(posedge sigIn);
            #1;
        end
    endtask

    task automatic do_reset();
        edges(1, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        @(posedge sigIn);
        #1;
        total++;
        if (count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: got %h, required 0000", count);
        end
        chk_on = 1'b1;
        edges(3, 1'b0, 1'b0);
        total++;
        if (count !== 16'h0000) begin
            bad++;
            $display("FAIL idle_after_reset: got %h, required 0000", count);
        end
    endtask

    task automatic test_count_1003();
        do_reset();
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0001) begin
            bad++;
            $display("FAIL first_edge_latency: got %h, required 0001", count);
        end
        edges(1002, 1'b1, 1'b0);
        total++;
        if (count !== 16'h1003) begin
            bad++;
            $display("FAIL count_1003: got %h, required 1003", count);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        edges(550, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0550) begin
            bad++;
            $display("FAIL count_550: got %h, required 0550", count);
        end
        edges(1, 1'b1, 1'b1);
        total++;
        if (count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_over_enable: got %h, required 0000", count);
        end
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0001) begin
            bad++;
            $display("FAIL resume_after_reset: got %h, required 0001", count);
        end
    endtask

    task automatic test_carry();
        do_reset();
        edges(9, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0009) begin
            bad++;
            $display("FAIL count_9: got %h, required 0009", count);
        end
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0010) begin
            bad++;
            $display("FAIL carry_units: got %h, required 0010", count);
        end
        edges(89, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0099) begin
            bad++;
            $display("FAIL count_99: got %h, required 0099", count);
        end
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0100) begin
            bad++;
            $display("FAIL carry_tens: got %h, required 0100", count);
        end
        do_reset();
        edges(999, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0999) begin
            bad++;
            $display("FAIL count_999: got %h, required 0999", count);
        end
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h1000) begin
            bad++;
            $display("FAIL carry_multi: got %h, required 1000", count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        edges(9999, 1'b1, 1'b0);
        total++;
        if (count !== 16'h9999) begin
            bad++;
            $display("FAIL count_9999: got %h, required 9999", count);
        end
        edges(1, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap: got %h, required 0000", count);
        end
        edges(10, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0010) begin
            bad++;
            $display("FAIL after_wrap: got %h, required 0010", count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        edges(123, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0123) begin
            bad++;
            $display("FAIL count_123: got %h, required 0123", count);
        end
        for (int i = 0; i < 20; i++) begin
            edges(1, 1'b0, 1'b0);
            total++;
            if (count !== 16'h0123) begin
                bad++;
                $display("FAIL hold[%0d]: got %h, required 0123", i, count);
            end
        end
        // Pulses on enable and reset that end before the edge must be ignored.
        enable = 1'b1;
        reset  = 1'b1;
        #2;
        enable = 1'b0;
        reset  = 1'b0;
        @(posedge sigIn);
        #1;
        total++;
        if (count !== 16'h0123) begin
            bad++;
            $display("FAIL between_edge_pulse: got %h, required 0123", count);
        end
        edges(5, 1'b1, 1'b0);
        total++;
        if (count !== 16'h0128) begin
            bad++;
            $display("FAIL resume_128: got %h, required 0128", count);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        #2;
        test_reset();
        test_count_1003();
        test_reset_priority();
        test_carry();
        test_wrap();
        test_hold();
        chk_on = 1'b0;
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
